aes_inv_key_sched: RTL

- Sequential decryption-side key scheduler: produces AES round keys in reverse order, round NR first and round 0 last, for the inverse cipher datapath.
- Phase 1 (EXPAND) runs the standard schedule forward, one 32-bit word per cycle, keeping only a sliding window of NK words.
- Phase 2 (OUT) walks the schedule backward using the inverse recurrence and streams 128-bit round keys over a valid/ready handshake.
- Storage is O(NK) words rather than the full (NR+1)*128-bit flat key bus.

---
 rtl/aes_inv_key_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/aes_inv_key_sched.sv
// Decryption-side AES key scheduler: expands the key forward through an nk-word window,
// then walks the schedule backward and streams round keys nr..0 over valid/ready.
//
// state     | meaning
// st_idle   | waiting for start
// st_expand | one forward schedule word per cycle until the window holds the last words
// st_out    | backward steps interleaved with round-key emission
module aes_inv_key_sched #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [0:nk*32-1]  key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [0:127]      rk_out,
  output logic [3:0]        rk_round,
  output logic              done
);

  localparam int jmax = 4 * (nr + 1) - nk;

  localparam logic [0:2047] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {st_idle, st_expand, st_out} state_t;

  state_t      state, state_nx;
  logic [31:0] win [nk];
  logic [5:0]  j;
  logic [3:0]  r;
  logic        done_q;
  int          i_cur;
  int          k;
  logic [31:0] f_in, f_out, new_word;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return sbox_flat[int'(b) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    case (n)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One shared transform: forward uses the top word, backward the one below it.
  always_comb begin
    i_cur = (state == st_out) ? int'(j) + nk - 1 : int'(j) + nk;
    f_in  = (state == st_out) ? win[nk-2] : win[nk-1];
    f_out = f_in;
    if (i_cur % nk == 0)
      f_out = sub_word({f_in[23:0], f_in[31:24]}) ^ {rcon(i_cur / nk), 24'h0};
    else if (nk == 8 && i_cur % nk == 4)
      f_out = sub_word(f_in);
    new_word = (state == st_out) ? (win[nk-1] ^ f_out) : (win[0] ^ f_out);
  end

  // A key is emitted once the window top lines up with its last word (or j has bottomed out),
  // which keeps the spacing at four backward steps per round.
  always_comb begin
    rk_valid = (state == st_out) && ((int'(j) + nk - 4 <= 4 * int'(r)) || (j == '0));
    rk_out   = '0;
    rk_round = '0;
    k        = 4 * int'(r) - int'(j);
    if (rk_valid) begin
      rk_round = r;
      for (int q = 0; q < 4; q++)
        for (int m = 0; m < nk; m++)
          if (m == k + q) rk_out[q*32 +: 32] = win[m];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      st_idle:   if (start) state_nx = st_expand;
      st_expand: if (j == 6'(jmax - 1)) state_nx = st_out;
      st_out:    if (rk_valid && rk_ready && r == '0) state_nx = st_idle;
      default:   state_nx = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= st_idle;
      j      <= '0;
      r      <= '0;
      done_q <= 1'b0;
      for (int m = 0; m < nk; m++) win[m] <= '0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      case (state)
        st_idle: if (start) begin
          for (int m = 0; m < nk; m++) win[m] <= key_in[m*32 +: 32];
          j <= '0;
          r <= 4'(nr);
        end
        st_expand: begin
          for (int m = 0; m < nk - 1; m++) win[m] <= win[m+1];
          win[nk-1] <= new_word;
          j <= j + 6'd1;
        end
        st_out: begin
          if (rk_valid) begin
            if (rk_ready) begin
              if (r == '0) done_q <= 1'b1;
              else         r <= r - 4'd1;
            end
          end else begin
            for (int m = 1; m < nk; m++) win[m] <= win[m-1];
            win[0] <= new_word;
            j <= j - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != st_idle);
  assign done = done_q;

endmodule
